// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: buffers the 64-bit fetch packet across ID stalls and
// drops instruction-RAM responses that were orphaned by a pipeline flush.
module if_fetch_stage #(
   parameter int PC_W  = 32,
   parameter int EXC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid_i,
   input  logic [PC_W-1:0]   pc1_i,
   input  logic [PC_W-1:0]   pc2_i,
   input  logic              line1_excep_en_i,
   input  logic [EXC_W-1:0]  line1_excep_type_i,
   input  logic              line2_excep_en_i,
   input  logic [EXC_W-1:0]  line2_excep_type_i,
   input  logic              inst_ram_req_i,
   input  logic              inst_data_ok_i,
   input  logic [63:0]       inst_rdata_i,
   input  logic              excep_flush_i,
   input  logic              banch_flush_i,
   input  logic              id_allowin_i,
   output logic              if_allowin_o,
   output logic              if_to_id_valid_o,
   output logic [PC_W-1:0]   pc1_o,
   output logic [PC_W-1:0]   pc2_o,
   output logic [31:0]       inst1_o,
   output logic [31:0]       inst2_o,
   output logic              line1_excep_en_o,
   output logic [EXC_W-1:0]  line1_excep_type_o,
   output logic              line2_excep_en_o,
   output logic [EXC_W-1:0]  line2_excep_type_o,
   output logic [1:0]        discard_cnt_o
);

   logic        buf_valid;
   logic [63:0] buf_data;
   logic [1:0]  discard_cnt;

   logic        waiting;
   logic        live_ok;
   logic        drop_ok;
   logic        ready_go;
   logic        flush;
   logic        handoff;
   logic        capture;
   logic        cnt_inc;
   logic        cnt_dec;
   logic [63:0] inst_pkt;

   assign flush    = excep_flush_i | banch_flush_i;
   assign waiting  = if_valid_i & inst_ram_req_i & ~buf_valid;
   assign live_ok  = inst_data_ok_i & (discard_cnt == 2'd0);
   assign drop_ok  = inst_data_ok_i & (discard_cnt != 2'd0);
   assign ready_go = ~inst_ram_req_i | buf_valid | live_ok;

   assign if_to_id_valid_o = if_valid_i & ready_go & ~flush;
   assign if_allowin_o     = ~if_valid_i | (ready_go & id_allowin_i) | flush;

   assign handoff = if_to_id_valid_o & id_allowin_i;
   assign capture = waiting & live_ok & ~id_allowin_i & ~flush;

   // A response landing in the same cycle as the flush is consumed here, so it
   // does not count as orphaned.
   assign cnt_inc = flush & waiting & ~live_ok;
   assign cnt_dec = drop_ok;

   always_comb begin
      inst_pkt = inst_rdata_i;
      if (!inst_ram_req_i) begin
         inst_pkt = 64'h0;
      end else if (buf_valid) begin
         inst_pkt = buf_data;
      end
   end

   assign inst1_o            = inst_pkt[31:0];
   assign inst2_o            = inst_pkt[63:32];
   assign pc1_o              = pc1_i;
   assign pc2_o              = pc2_i;
   assign line1_excep_en_o   = line1_excep_en_i;
   assign line1_excep_type_o = line1_excep_type_i;
   assign line2_excep_en_o   = line2_excep_en_i;
   assign line2_excep_type_o = line2_excep_type_i;
   assign discard_cnt_o      = discard_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
         buf_data  <= 64'h0;
      end else if (handoff || flush) begin
         buf_valid <= 1'b0;
      end else if (capture) begin
         buf_valid <= 1'b1;
         buf_data  <= inst_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         discard_cnt <= 2'd0;
      end else if (cnt_inc && !cnt_dec && discard_cnt != 2'd2) begin
         discard_cnt <= discard_cnt + 2'd1;
      end else if (cnt_dec && !cnt_inc && discard_cnt != 2'd0) begin
         discard_cnt <= discard_cnt - 2'd1;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: emulates the upstream register and an in-order RAM,
// predicts handoffs with an orphan-tracking model and scores them in a monitor.
module tb_if_fetch_stage;
   localparam int PC_W  = 32;
   localparam int EXC_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              if_valid_i;
   logic [PC_W-1:0]   pc1_i, pc2_i;
   logic              line1_excep_en_i, line2_excep_en_i;
   logic [EXC_W-1:0]  line1_excep_type_i, line2_excep_type_i;
   logic              inst_ram_req_i, inst_data_ok_i;
   logic [63:0]       inst_rdata_i;
   logic              excep_flush_i, banch_flush_i, id_allowin_i;
   logic              if_allowin_o, if_to_id_valid_o;
   logic [PC_W-1:0]   pc1_o, pc2_o;
   logic [31:0]       inst1_o, inst2_o;
   logic              line1_excep_en_o, line2_excep_en_o;
   logic [EXC_W-1:0]  line1_excep_type_o, line2_excep_type_o;
   logic [1:0]        discard_cnt_o;

   always #5 clk = ~clk;

   if_fetch_stage #(.PC_W(PC_W), .EXC_W(EXC_W)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i),
      .pc1_i(pc1_i), .pc2_i(pc2_i),
      .line1_excep_en_i(line1_excep_en_i), .line1_excep_type_i(line1_excep_type_i),
      .line2_excep_en_i(line2_excep_en_i), .line2_excep_type_i(line2_excep_type_i),
      .inst_ram_req_i(inst_ram_req_i), .inst_data_ok_i(inst_data_ok_i),
      .inst_rdata_i(inst_rdata_i), .excep_flush_i(excep_flush_i),
      .banch_flush_i(banch_flush_i), .id_allowin_i(id_allowin_i),
      .if_allowin_o(if_allowin_o), .if_to_id_valid_o(if_to_id_valid_o),
      .pc1_o(pc1_o), .pc2_o(pc2_o), .inst1_o(inst1_o), .inst2_o(inst2_o),
      .line1_excep_en_o(line1_excep_en_o), .line1_excep_type_o(line1_excep_type_o),
      .line2_excep_en_o(line2_excep_en_o), .line2_excep_type_o(line2_excep_type_o),
      .discard_cnt_o(discard_cnt_o)
   );

   typedef struct packed {
      logic        v;
      logic        req;
      logic [31:0] pc1;
      logic [31:0] pc2;
      logic        e1;
      logic        e2;
      logic [7:0]  t1;
      logic [7:0]  t2;
      logic [63:0] data;
   } fetch_t;

   typedef struct packed {
      logic        orphan;
      logic [63:0] data;
   } resp_t;

   typedef struct packed {
      logic [31:0] pc1;
      logic [31:0] pc2;
      logic [31:0] i1;
      logic [31:0] i2;
      logic        e1;
      logic [7:0]  t1;
      logic        e2;
      logic [7:0]  t2;
   } pkt_t;

   fetch_t      cur;
   fetch_t      plan_q[$];
   resp_t       ram_q[$];
   pkt_t        sb_q[$];
   logic        has_data;
   logic [63:0] hold;
   logic        chk_en;
   logic [3:0]  exp_ctl;
   pkt_t        mon_got, mon_exp;
   int          vectors, miscompares;

   function automatic fetch_t rand_fetch();
      fetch_t f;
      f.v    = ($urandom_range(0, 9) < 8);
      f.req  = f.v && ($urandom_range(0, 9) < 8);
      f.pc1  = $urandom & ~32'h3;
      f.pc2  = f.pc1 + 32'd4;
      f.e1   = ($urandom_range(0, 7) == 0);
      f.e2   = ($urandom_range(0, 7) == 0);
      f.t1   = 8'($urandom);
      f.t2   = 8'($urandom);
      f.data = {$urandom, $urandom};
      return f;
   endfunction

   function automatic fetch_t mk(input logic req, input logic [31:0] pc,
                                 input logic [63:0] d, input logic e1, input logic [7:0] t1);
      fetch_t f;
      f.v = 1'b1; f.req = req; f.pc1 = pc; f.pc2 = pc + 32'd4;
      f.e1 = e1; f.t1 = t1; f.e2 = 1'b0; f.t2 = 8'h0; f.data = d;
      return f;
   endfunction

   task automatic idle_inputs();
      if_valid_i = 0; pc1_i = '0; pc2_i = '0;
      line1_excep_en_i = 0; line1_excep_type_i = '0;
      line2_excep_en_i = 0; line2_excep_type_i = '0;
      inst_ram_req_i = 0; inst_data_ok_i = 0; inst_rdata_i = '0;
      excep_flush_i = 0; banch_flush_i = 0; id_allowin_i = 0;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   // One clock cycle: drive from the model, publish expectations, advance the model.
   task automatic cycle(input bit want_ok, input bit want_flush, input bit alw);
      int          orph;
      int          pick;
      bit          data_ok, front_live, front_drop, pend, would, fl;
      bit          ready, e_valid, e_allow;
      resp_t       r;
      pkt_t        p;
      logic [63:0] d;
      orph = 0;
      foreach (ram_q[i]) if (ram_q[i].orphan) orph++;
      data_ok = want_ok && (ram_q.size() > 0);
      front_live = 0; front_drop = 0;
      if (data_ok) begin
         front_live = !ram_q[0].orphan;
         front_drop = ram_q[0].orphan;
      end
      pend  = cur.v && cur.req && !has_data;
      would = pend && !front_live;
      fl    = want_flush && ((orph - int'(front_drop) + int'(would)) <= 2);

      if_valid_i = cur.v; inst_ram_req_i = cur.req;
      pc1_i = cur.pc1; pc2_i = cur.pc2;
      line1_excep_en_i = cur.e1; line1_excep_type_i = cur.t1;
      line2_excep_en_i = cur.e2; line2_excep_type_i = cur.t2;
      inst_data_ok_i = data_ok;
      if (data_ok) inst_rdata_i = ram_q[0].data;
      else         inst_rdata_i = {$urandom, $urandom};
      pick = $urandom_range(0, 2);
      excep_flush_i = fl && (pick != 1);
      banch_flush_i = fl && (pick != 0);
      id_allowin_i  = alw;

      ready   = !cur.req || has_data || front_live;
      e_valid = cur.v && ready && !fl;
      e_allow = !cur.v || (ready && alw) || fl;
      if (e_valid && alw) begin
         if (!cur.req)     d = 64'h0;
         else if (has_data) d = hold;
         else              d = ram_q[0].data;
         p.pc1 = cur.pc1; p.pc2 = cur.pc2; p.i1 = d[31:0]; p.i2 = d[63:32];
         p.e1 = cur.e1; p.t1 = cur.t1; p.e2 = cur.e2; p.t2 = cur.t2;
         sb_q.push_back(p);
      end
      exp_ctl = {e_valid, e_allow, 2'(orph)};
      chk_en  = 1'b1;

      @(posedge clk);
      if (data_ok) begin
         r = ram_q.pop_front();
         if (!r.orphan && !fl && !(e_valid && alw)) begin
            has_data = 1'b1;
            hold     = r.data;
         end
      end
      if (fl && would) begin
         r = ram_q.pop_back();
         r.orphan = 1'b1;
         ram_q.push_back(r);
      end
      if (e_allow) begin
         if (plan_q.size() > 0) cur = plan_q.pop_front();
         else                   cur = rand_fetch();
         has_data = 1'b0;
         if (cur.v && cur.req) begin
            r.orphan = 1'b0;
            r.data   = cur.data;
            ram_q.push_back(r);
         end
      end
      #1;
   endtask

   task automatic resync_after_reset();
      idle_inputs();
      cur = '0; has_data = 1'b0; hold = '0;
      ram_q.delete();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if ({if_to_id_valid_o, if_allowin_o, discard_cnt_o} !== exp_ctl) begin
            miscompares++;
            $display("FAIL ctl t=%0t got valid,allowin,cnt=%b required=%b", $time,
                     {if_to_id_valid_o, if_allowin_o, discard_cnt_o}, exp_ctl);
         end
         if (if_to_id_valid_o && id_allowin_i) begin
            vectors++;
            mon_got = {pc1_o, pc2_o, inst1_o, inst2_o, line1_excep_en_o, line1_excep_type_o,
                       line2_excep_en_o, line2_excep_type_o};
            if (sb_q.size() == 0) begin
               miscompares++;
               $display("FAIL pkt_unexpected t=%0t got=%h required=none", $time, mon_got);
            end else begin
               mon_exp = sb_q.pop_front();
               if (mon_got !== mon_exp) begin
                  miscompares++;
                  $display("FAIL pkt t=%0t got=%h required=%h", $time, mon_got, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      vectors = 0; miscompares = 0; chk_en = 1'b0; exp_ctl = '0;
      cur = '0; has_data = 1'b0; hold = '0;
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(if_to_id_valid_o), 64'd0);
      chk("rst_allowin", 64'(if_allowin_o), 64'd1);
      chk("rst_cnt", 64'(discard_cnt_o), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      plan_q.push_back(mk(1, 32'h1C000000, 64'h02800404_02800C0C, 0, 8'h0)); // F1 hit
      plan_q.push_back(mk(1, 32'h1C000008, 64'h11112222_33334444, 0, 8'h0)); // F2 stall
      plan_q.push_back(mk(1, 32'h1C000010, 64'hDEAD0000_BEEF0000, 0, 8'h0)); // F3 flushed
      plan_q.push_back(mk(1, 32'h1C000020, 64'h55556666_77778888, 0, 8'h0)); // F4
      plan_q.push_back(mk(1, 32'h1C000030, 64'hAAAA0001_AAAA0002, 0, 8'h0)); // F5 flushed
      plan_q.push_back(mk(1, 32'h1C000038, 64'hAAAA0003_AAAA0004, 0, 8'h0)); // F6 flushed
      plan_q.push_back(mk(1, 32'h1C000040, 64'hAAAA0005_AAAA0006, 0, 8'h0)); // F7 flushed
      plan_q.push_back(mk(1, 32'h1C000048, 64'h0BAD0BAD_600DF00D, 0, 8'h0)); // F8
      plan_q.push_back(mk(0, 32'h1C000050, 64'h0, 1, 8'h05));                // F9 exception
      plan_q.push_back(mk(1, 32'h1C000058, 64'h1, 0, 8'h0));                 // F10 flushed
      plan_q.push_back(mk(1, 32'h1C000060, 64'h2, 0, 8'h0));                 // F11 flushed
      plan_q.push_back(mk(1, 32'h1C000068, 64'h3, 0, 8'h0));                 // F12

      cycle(0, 0, 1);
      cycle(1, 0, 1);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(0, 1, 1);
      cycle(1, 0, 1);
      cycle(1, 0, 1);
      cycle(0, 1, 1);
      cycle(0, 1, 1);
      cycle(1, 1, 1);
      cycle(1, 0, 1);
      cycle(1, 0, 1);
      cycle(1, 0, 1);
      cycle(0, 0, 1);
      cycle(0, 1, 1);
      cycle(0, 1, 1);
      cycle(0, 0, 0);

      // Reset between edges with two orphans outstanding.
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_cnt", 64'(discard_cnt_o), 64'd0);
      resync_after_reset();

      // Reset between edges while a packet sits in the buffer.
      plan_q.push_back(mk(1, 32'h1C000100, 64'hCAFE0001_CAFE0002, 0, 8'h0));
      cycle(0, 0, 1);
      cycle(1, 0, 0);
      chk_en = 1'b0;
      inst_data_ok_i = 1'b0; excep_flush_i = 1'b0; banch_flush_i = 1'b0;
      #1 chk("pre_rst_buf_valid", 64'(if_to_id_valid_o), 64'd1);
      rst_n = 1'b0;
      #1 chk("mid_rst_buf_valid", 64'(if_to_id_valid_o), 64'd0);
      chk("mid_rst_allowin", 64'(if_allowin_o), 64'd0);
      sb_q.delete();
      resync_after_reset();

      plan_q.push_back(mk(1, 32'h1C000200, 64'h12345678_9ABCDEF0, 0, 8'h0));
      cycle(0, 0, 1);
      cycle(1, 0, 1);

      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 8,
               $urandom_range(0, 99) < ((i < 1500) ? 70 : 30));
      end
      chk_en = 1'b0;
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch (IF) stage of the dual-issue front end. Sits directly downstream of the pre-IF→IF pipeline register, whose outputs feed it. It consumes the registered PC pair, exception tags and request flag, and waits for the instruction-RAM response. It buffers the 64-bit fetch packet while ID stalls, discards responses orphaned by flushes, and hands {pc, inst, exception} for both lines to ID with a valid/allowin handshake.

## Interface
- PC_W, 32, PC width
- EXC_W, 8, exception-type width per line
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- if_valid_i  in  1  IF stage holds a valid fetch (from pre-IF→IF register)
- pc1_i / pc2_i  in  PC_W  line-1 / line-2 PC
- line1_excep_en_i / line2_excep_en_i  in  1  exception already detected on the line
- line1_excep_type_i / line2_excep_type_i  in  EXC_W  exception code
- inst_ram_req_i  in  1  a RAM request was issued for this fetch (0 = no response will arrive)
- inst_data_ok_i  in  1  RAM response valid this cycle
- inst_rdata_i  in  64  response; [31:0] = line 1, [63:32] = line 2
- excep_flush_i, banch_flush_i  in  1  pipeline flush (exception / branch mispredict)
- id_allowin_i  in  1  ID can accept this cycle
- if_allowin_o  out  1  IF can accept a new fetch at the next edge
- if_to_id_valid_o  out  1  packet offered to ID
- pc1_o, pc2_o  out  PC_W  pass-through PCs
- inst1_o, inst2_o  out  32  instruction words
- line1_excep_en_o, line1_excep_type_o, line2_excep_en_o, line2_excep_type_o  out  1/EXC_W  pass-through exception tags
- discard_cnt_o  out  2  pending responses to drop (debug/visibility)

## Operation
- State: buf_valid (1), buf_data (64), discard_cnt (2, range 0..2).
- waiting = if_valid_i & inst_ram_req_i & ~buf_valid.
- live_ok = inst_data_ok_i & (discard_cnt == 0).
- drop_ok = inst_data_ok_i & (discard_cnt != 0). Such a response is never forwarded or buffered.
- ready_go = ~inst_ram_req_i | buf_valid | live_ok.
- flush = excep_flush_i | banch_flush_i.
- if_to_id_valid_o = if_valid_i & ready_go & ~flush.
- if_allowin_o = ~if_valid_i | (ready_go & id_allowin_i) | flush.
- Instruction mux:
  - inst_ram_req_i = 0: inst1_o = inst2_o = 32'h0.
  - Else if buf_valid: take buf_data.
  - Else: take inst_rdata_i.
- PCs and exception tags are combinational pass-through of the inputs.
- Buffer capture: when waiting & live_ok & ~id_allowin_i & ~flush, set buf_valid = 1 and buf_data = inst_rdata_i.
- Buffer clear: when (if_to_id_valid_o & id_allowin_i) or flush, clear buf_valid. buf_data is held.
- Discard counter:
  - inc = flush & waiting & ~live_ok. The current request is orphaned.
  - dec = drop_ok.
  - next = cnt + inc − dec.
  - inc and dec together leave the count unchanged.
  - Saturate at 2. Never underflow.
- A flush with live_ok in the same cycle consumes that response, drops it, and does not increment the counter.
- A response arriving when ~waiting and discard_cnt == 0 is a protocol error. It is ignored and no state changes.

## Timing
- Reset (async assert, rst_n low): buf_valid = 0, buf_data = 0, discard_cnt = 0, effective immediately with no clock edge.
- Reset output values with if_valid_i = 0: if_to_id_valid_o = 0, if_allowin_o = 1.
- Deassertion is sampled at clk; the first update is at the next edge.
- Hit path is zero latency: data_ok in cycle N with id_allowin_i = 1 gives if_to_id_valid_o = 1 in cycle N.
- Buffered path: capture at edge N→N+1. The packet is offered from cycle N+1 until ID accepts.
- flush forces if_to_id_valid_o = 0 in the same cycle. The buffer and counter update at the next edge.
- All registers update only on posedge clk, except for asynchronous reset.

## Test plan
- Normal hit: if_valid_i = 1, req = 1, pc1 = 0x1C000000, pc2 = 0x1C000004, data_ok with rdata = 0x02800404_02800C0C, id_allowin = 1 → same cycle: valid = 1, inst1 = 0x02800C0C, inst2 = 0x02800404, allowin = 1. Buffer stays empty.
- ID stall: data_ok with id_allowin = 0 → buf_valid = 1 next cycle, valid held at 1, allowin = 0. Drop data_ok, then raise id_allowin → buffered words output and allowin = 1. buf_valid = 0 next cycle.
- Flush while waiting: banch_flush in cycle N with no data_ok → discard_cnt = 1. Next data_ok is dropped (valid = 0) and cnt → 0. The following data_ok for a new fetch is delivered.
- Double orphan: two flushes each while waiting → cnt = 2. Two data_ok are dropped (cnt 2→1→0). A flush coinciding with a drop_ok while waiting keeps cnt unchanged.
- Exception line: req = 0, line1_excep_en = 1, type = 0x05 → valid = 1 immediately with no data_ok, inst1 = inst2 = 0, tags passed through, cnt unaffected.
- Async reset mid-operation: with buf_valid = 1 and cnt = 2, pull rst_n low between clock edges → buf_valid = 0 and cnt = 0 before the next edge. After release, normal hit works.
